// File: rtl/spi_csr_master_if.sv
//==============================================================================
// Module   : spi_csr_master_if
// Brief    : On-chip CSR bus bundle (address, write data/enable, read
//            enable/data) between the SPI front end and the register map.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface spi_csr_master_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] write_data_o;
    logic                  write_en_o;
    logic                  read_en_o;
    logic [DATA_WIDTH-1:0] read_data_i;

    // Bus master: the SPI front end
    modport master (
        output addr_o,
        output write_data_o,
        output write_en_o,
        output read_en_o,
        input  read_data_i
    );

    // Bus slave: the register map
    modport slave (
        input  addr_o,
        input  write_data_o,
        input  write_en_o,
        input  read_en_o,
        output read_data_i
    );
endinterface

`default_nettype wire

// File: rtl/spi_csr_master.sv
//==============================================================================
// Module   : spi_csr_master
// Brief    : SPI mode-0 slave that turns 16-bit host frames
//            {RnW, addr[6:0], data[7:0]} into single CSR bus reads/writes.
//            SPI pins are oversampled in the clk_i domain.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_csr_master #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 2,
    parameter int WR_HOLD    = 3
) (
    input  wire              clk_i,
    input  wire              rst_i,
    input  wire              spi_sclk_i,
    input  wire              spi_csn_i,
    input  wire              spi_mosi_i,
    output logic             spi_miso_o,
    output logic             spi_miso_oe_o,
    spi_csr_master_if.master csr,
    output logic             frame_err_o
);
    localparam int c_FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam int c_ACC_MAX    = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
    localparam int c_ACC_W      = $clog2(c_ACC_MAX + 1);

    // Bit index (0-based) of the last header bit and of the last frame bit
    localparam logic [c_CNT_W-1:0] c_HDR_LAST   = c_CNT_W'(ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(c_FRAME_BITS - 1);
    // Read: enable for counts 0..RD_LAT-1, capture data at count RD_LAT
    localparam logic [c_ACC_W-1:0] c_RD_DONE    = c_ACC_W'(RD_LAT);
    // Write: enable for counts 0..WR_HOLD-1, leave on the last one
    localparam logic [c_ACC_W-1:0] c_WR_DONE    = c_ACC_W'(WR_HOLD - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_HDR    = 3'd1;
    localparam logic [2:0] c_RD_ACC = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_WR_ACC = 3'd4;
    localparam logic [2:0] c_TAIL   = 3'd5;

    logic                  r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic                  r_csn_meta, r_csn_sync, r_csn_d;
    logic                  r_mosi_meta, r_mosi_sync;
    logic [2:0]            r_state, w_state_next;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_ACC_W-1:0]    r_acc_cnt;
    logic [ADDR_WIDTH-1:0] r_hdr;
    logic [DATA_WIDTH-2:0] r_wdat;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_rnw;
    logic                  r_miso;
    logic                  r_frame_err;
    logic                  w_abort;

    // Edge/level decode on the synchronised pins
    wire w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    wire w_sclk_fall = ~r_sclk_sync & r_sclk_d;
    wire w_csn_fall  = r_csn_d & ~r_csn_sync;
    wire w_csn_high  = r_csn_sync;
    // A rising edge only counts while the host still holds chip select
    wire w_shift     = w_sclk_rise & ~w_csn_high;

    // Shift-in views including the bit arriving on this edge
    wire [ADDR_WIDTH:0]   w_hdr_next  = {r_hdr, r_mosi_sync};
    wire [DATA_WIDTH-1:0] w_wdat_next = {r_wdat, r_mosi_sync};

    // Two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_csn_meta  <= 1'b1;
            r_csn_sync  <= 1'b1;
            r_csn_d     <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= spi_sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_csn_meta  <= spi_csn_i;
            r_csn_sync  <= r_csn_meta;
            r_csn_d     <= r_csn_sync;
            r_mosi_meta <= spi_mosi_i;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_csn_fall) w_state_next = c_HDR;
            end
            c_HDR: begin
                if (w_csn_high)
                    w_state_next = c_IDLE;
                else if (w_sclk_rise && (r_bit_cnt == c_HDR_LAST))
                    w_state_next = w_hdr_next[ADDR_WIDTH] ? c_RD_ACC : c_DATA;
            end
            c_RD_ACC: begin
                // The read always runs to completion; an early CS release
                // is only acted on once the data slot has passed.
                if (r_acc_cnt == c_RD_DONE)
                    w_state_next = w_csn_high ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (w_csn_high)
                    w_state_next = c_IDLE;
                else if (w_sclk_rise && (r_bit_cnt == c_FRAME_LAST))
                    w_state_next = r_rnw ? c_TAIL : c_WR_ACC;
            end
            c_WR_ACC: begin
                if (r_acc_cnt == c_WR_DONE) w_state_next = c_TAIL;
            end
            c_TAIL: begin
                if (w_csn_high) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM outputs: bus enables and the abort condition
    always_comb begin
        csr.read_en_o  = 1'b0;
        csr.write_en_o = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            c_HDR, c_DATA: w_abort = w_csn_high;
            c_RD_ACC: begin
                csr.read_en_o = (r_acc_cnt != c_RD_DONE);
                w_abort       = w_csn_high && (r_acc_cnt == c_RD_DONE);
            end
            c_WR_ACC: csr.write_en_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: counters, shift registers, bus address/data, MISO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt        <= '0;
            r_acc_cnt        <= '0;
            r_hdr            <= '0;
            r_wdat           <= '0;
            r_tx             <= '0;
            r_rnw            <= 1'b0;
            r_miso           <= 1'b0;
            r_frame_err      <= 1'b0;
            csr.addr_o       <= '0;
            csr.write_data_o <= '0;
        end else begin
            r_frame_err <= w_abort;

            if (r_state != w_state_next)
                r_acc_cnt <= '0;
            else if ((r_state == c_RD_ACC) || (r_state == c_WR_ACC))
                r_acc_cnt <= r_acc_cnt + 1'b1;

            case (r_state)
                c_IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= 1'b0;
                end
                c_HDR: begin
                    if (w_shift) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_hdr     <= w_hdr_next[ADDR_WIDTH-1:0];
                        if (r_bit_cnt == c_HDR_LAST) begin
                            csr.addr_o <= w_hdr_next[ADDR_WIDTH-1:0];
                            r_rnw      <= w_hdr_next[ADDR_WIDTH];
                        end
                    end
                end
                c_RD_ACC: begin
                    if (r_acc_cnt == c_RD_DONE) r_tx <= csr.read_data_i;
                end
                c_DATA: begin
                    if (w_shift) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_wdat    <= w_wdat_next[DATA_WIDTH-2:0];
                        if ((r_bit_cnt == c_FRAME_LAST) && !r_rnw)
                            csr.write_data_o <= w_wdat_next;
                    end
                    // Write frames keep MISO at 0; reads shift out MSB first
                    if (r_rnw && w_sclk_fall) begin
                        r_miso <= r_tx[DATA_WIDTH-1];
                        r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = ~r_csn_sync;
    assign frame_err_o   = r_frame_err;

endmodule

`default_nettype wire
